// File: rtl/hid_dense_layer.sv
// hid_dense_layer
//   Fully-connected layer fed by rand_layer. On a cycle where run is high in
//   IDLE, the IN_DIM-wide input vector d is latched. The layer then walks an
//   external synchronous ROM with one multiply-accumulate per word and forms
//   OUT_DIM outputs q_o = act(sum_i W[o][i]*x_i + b_o). The result is held
//   with valid high until run drops.
//
//   ROM layout: word o*(IN_DIM+1)+i is W[o][i] for i < IN_DIM, and word
//   o*(IN_DIM+1)+IN_DIM is the bias b_o.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   run     upstream valid (level); high means d is stable
//   d       input vector, element i at d[i*N_LEN +: N_LEN]
//   w_en    ROM read enable
//   w_addr  ROM address (holds its last value while w_en is low)
//   w_data  ROM data, one cycle after w_en/w_addr
//   valid   q holds a complete result
//   q       output vector, element o at q[o*N_LEN +: N_LEN]
module hid_dense_layer #(
  parameter int IN_DIM  = 8,
  parameter int OUT_DIM = 8,
  parameter int N_LEN   = 16,
  parameter int F_LEN   = 8,
  parameter int RELU    = 1,
  parameter int A_LEN   = $clog2(OUT_DIM*(IN_DIM+1))
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic [IN_DIM*N_LEN-1:0]    d,
  output logic                       w_en,
  output logic [A_LEN-1:0]           w_addr,
  input  logic [N_LEN-1:0]           w_data,
  output logic                       valid,
  output logic [OUT_DIM*N_LEN-1:0]   q
);

  localparam int T     = OUT_DIM*(IN_DIM+1);
  localparam int CW    = $clog2(T+1);
  localparam int IW    = $clog2(IN_DIM+1);
  localparam int OW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int ACC_W = 2*N_LEN + $clog2(IN_DIM+1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FLUSH, S_DONE} state_t;

  state_t state_q, state_d;

  // Issue side: counters of the next word to request.
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       ii_q;
  logic [OW-1:0]       oi_q;
  // Request stage: the word currently presented to the ROM.
  logic                w_en_q;
  logic [A_LEN-1:0]    w_addr_q;
  logic [IW-1:0]       wi_q;
  logic [OW-1:0]       wo_q;
  // Data stage: tags for the word arriving on w_data this cycle.
  logic                dv_q;
  logic [IW-1:0]       di_q;
  logic [OW-1:0]       do_q;

  logic [N_LEN-1:0]    x_q [IN_DIM];
  logic [N_LEN-1:0]    q_q [OUT_DIM];
  logic [ACC_W-1:0]    acc_q;

  logic [N_LEN-1:0]    xsel;
  logic signed [2*N_LEN-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] shr;
  logic [ACC_W-N_LEN:0] hi;
  logic [N_LEN-1:0]    res;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_CALC;
      S_CALC:  if (!run) state_d = S_IDLE;
               else if (cnt_q == CW'(T)) state_d = S_FLUSH;
      S_FLUSH: state_d = run ? S_DONE : S_IDLE;
      S_DONE:  if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // MAC arithmetic on the word arriving this cycle
  always_comb begin
    xsel = '0;
    for (int unsigned k = 0; k < IN_DIM; k++)
      if (di_q == IW'(k)) xsel = x_q[k];
    prod     = $signed(w_data) * $signed(xsel);
    prod_ext = {{(ACC_W-2*N_LEN){prod[2*N_LEN-1]}}, prod};
    bias_ext = {{(ACC_W-N_LEN-F_LEN){w_data[N_LEN-1]}}, w_data, {F_LEN{1'b0}}};
    sum_s    = $signed(acc_q + bias_ext);
    shr      = sum_s >>> F_LEN;
    // Value fits N_LEN bits only if everything from the N_LEN-1 bit up is a
    // pure sign extension.
    hi       = shr[ACC_W-1:N_LEN-1];
    if (hi != '0 && hi != '1)
      res = shr[ACC_W-1] ? {1'b1, {(N_LEN-1){1'b0}}} : {1'b0, {(N_LEN-1){1'b1}}};
    else
      res = shr[N_LEN-1:0];
    if (RELU != 0 && res[N_LEN-1]) res = '0;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      ii_q     <= '0;
      oi_q     <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      wi_q     <= '0;
      wo_q     <= '0;
      dv_q     <= 1'b0;
      di_q     <= '0;
      do_q     <= '0;
      acc_q    <= '0;
      for (int unsigned k = 0; k < IN_DIM; k++)  x_q[k] <= '0;
      for (int unsigned k = 0; k < OUT_DIM; k++) q_q[k] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          w_en_q <= 1'b0;
          dv_q   <= 1'b0;
          if (run) begin
            for (int unsigned k = 0; k < IN_DIM; k++)
              x_q[k] <= d[k*N_LEN +: N_LEN];
            cnt_q <= '0;
            ii_q  <= '0;
            oi_q  <= '0;
            acc_q <= '0;
          end
        end
        S_CALC, S_FLUSH: begin
          if (!run) begin
            w_en_q <= 1'b0;
            dv_q   <= 1'b0;
            acc_q  <= '0;
          end else begin
            if (cnt_q != CW'(T)) begin
              w_en_q   <= 1'b1;
              w_addr_q <= A_LEN'(cnt_q);
              wi_q     <= ii_q;
              wo_q     <= oi_q;
              cnt_q    <= cnt_q + CW'(1);
              if (ii_q == IW'(IN_DIM)) begin
                ii_q <= '0;
                oi_q <= oi_q + OW'(1);
              end else begin
                ii_q <= ii_q + IW'(1);
              end
            end else begin
              w_en_q <= 1'b0;
            end
            dv_q <= w_en_q;
            di_q <= wi_q;
            do_q <= wo_q;
            if (dv_q) begin
              if (di_q == IW'(IN_DIM)) begin
                for (int unsigned k = 0; k < OUT_DIM; k++)
                  if (do_q == OW'(k)) q_q[k] <= res;
                acc_q <= '0;
              end else begin
                acc_q <= acc_q + prod_ext;
              end
            end
          end
        end
        default: begin
          w_en_q <= 1'b0;
          dv_q   <= 1'b0;
        end
      endcase
    end
  end

  assign w_en   = w_en_q;
  assign w_addr = w_addr_q;
  assign valid  = (state_q == S_DONE);

  always_comb begin
    q = '0;
    for (int unsigned k = 0; k < OUT_DIM; k++)
      q[k*N_LEN +: N_LEN] = q_q[k];
  end

endmodule

// File: tb/tb_hid_dense_layer.sv
module tb_hid_dense_layer;
  localparam int IN_DIM = 8;
  localparam int OUT_DIM = 8;
  localparam int N = 16;
  localparam int T = OUT_DIM*(IN_DIM+1);
  localparam int LAT = T + 2;

  logic clk = 1'b0;
  logic rst, run;
  logic [IN_DIM*N-1:0] d;
  logic w_en0, w_en1, valid0, valid1;
  logic [6:0] w_addr0, w_addr1;
  logic [15:0] w_data0 = '0, w_data1 = '0;
  logic [OUT_DIM*N-1:0] q0, q1;

  logic [15:0] rom [T];
  logic [15:0] xv [IN_DIM];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Synchronous ROMs, one read port per DUT
  always @(posedge clk) begin
    if (w_en0) w_data0 <= rom[w_addr0];
    if (w_en1) w_data1 <= rom[w_addr1];
  end

  hid_dense_layer #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .N_LEN(16), .F_LEN(8), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .run(run), .d(d), .w_en(w_en0), .w_addr(w_addr0),
    .w_data(w_data0), .valid(valid0), .q(q0));

  hid_dense_layer #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .N_LEN(16), .F_LEN(8), .RELU(1)) dut1 (
    .clk(clk), .rst(rst), .run(run), .d(d), .w_en(w_en1), .w_addr(w_addr1),
    .w_data(w_data1), .valid(valid1), .q(q1));

  typedef struct {
    logic [15:0] wdiag, woff, beven, bodd, dadd, dmul;
    logic [15:0] e0_even, e0_odd, e1_even, e1_odd, emul;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_x();
    logic [127:0] v;
    for (int i = 0; i < IN_DIM; i++) v[i*N +: N] = xv[i];
    return v;
  endfunction

  // Reference: plain integer arithmetic over the ROM image and input vector
  function automatic logic [127:0] model(input bit relu);
    logic [127:0] r;
    longint s;
    for (int o = 0; o < OUT_DIM; o++) begin
      s = 0;
      for (int i = 0; i < IN_DIM; i++)
        s += longint'($signed(rom[o*(IN_DIM+1)+i])) * longint'($signed(xv[i]));
      s += longint'($signed(rom[o*(IN_DIM+1)+IN_DIM])) * 256;
      s = s >>> 8;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      r[o*N +: N] = s[15:0];
    end
    return r;
  endfunction

  task automatic fill_rom(input logic [15:0] wdiag, woff, beven, bodd);
    for (int o = 0; o < OUT_DIM; o++) begin
      for (int i = 0; i < IN_DIM; i++) rom[o*(IN_DIM+1)+i] = (o == i) ? wdiag : woff;
      rom[o*(IN_DIM+1)+IN_DIM] = (o % 2 == 0) ? beven : bodd;
    end
  endtask

  function automatic logic [15:0] small_rand();
    return 16'($urandom_range(0, 2047)) - 16'd1024;
  endfunction

  // Wait (bounded) for valid after edge 0 has just occurred; returns edge count
  task automatic wait_valid(input bit scramble, output int n);
    n = 0;
    while (n < LAT + 20) begin
      @(posedge clk);
      n++;
      #1;
      if (valid0) break;
      if (scramble && (n % 7 == 3)) d = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Start from IDLE with run low; returns results at the first valid edge
  task automatic do_job(input string name, input bit scramble,
                        output logic [127:0] r0, output logic [127:0] r1);
    int n;
    @(posedge clk); #1;
    d = pack_x();
    run = 1'b1;
    @(posedge clk);  // edge 0: capture
    wait_valid(scramble, n);
    check({name, " latency"}, 128'(n), 128'(LAT));
    check({name, " valid1"}, 128'(valid1), 128'(1));
    r0 = q0;
    r1 = q1;
  endtask

  task automatic end_job(input string name);
    run = 1'b0;
    @(posedge clk); #1;
    check({name, " valid drop"}, {126'd0, valid1, valid0}, 128'd0);
  endtask

  vec_t tbl [6];
  logic [127:0] r0, r1, e0, e1, m0, m1, qhold;
  bit hold_ok;
  int n;

  initial begin
    tbl[0] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0080,
               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0080};  // identity
    tbl[1] = '{16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 16'h7F00, 16'h0000,
               16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000};  // saturate high
    tbl[2] = '{16'h8100, 16'h8100, 16'h0000, 16'h0000, 16'h7F00, 16'h0000,
               16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000};  // saturate low
    tbl[3] = '{16'h0000, 16'h0000, 16'hFF00, 16'h0180, 16'h0100, 16'h0000,
               16'hFF00, 16'h0180, 16'h0000, 16'h0180, 16'h0000};  // relu / bias
    tbl[4] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000,
               16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};  // floor of -1/256
    tbl[5] = '{16'h0100, 16'h0000, 16'h7FFF, 16'h8000, 16'h0100, 16'h0000,
               16'h7FFF, 16'h8100, 16'h7FFF, 16'h0000, 16'h0000};  // bias near limits

    // Reset with run high: nothing may start
    rst = 1'b1;
    run = 1'b1;
    d = {$urandom, $urandom, $urandom, $urandom};
    fill_rom(16'h1234, 16'h0101, 16'h0202, 16'h0303);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("reset%0d ctl", c), {w_addr1, w_addr0, w_en1, w_en0, valid1, valid0}, 128'd0);
      check($sformatf("reset%0d q", c), q0 | q1, 128'd0);
    end
    run = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("post-reset idle%0d", c), {w_en1, w_en0, valid1, valid0}, 128'd0);
    end

    // Directed table
    for (int t = 0; t < 6; t++) begin
      fill_rom(tbl[t].wdiag, tbl[t].woff, tbl[t].beven, tbl[t].bodd);
      for (int i = 0; i < IN_DIM; i++) xv[i] = tbl[t].dadd + 16'(i) * tbl[t].dmul;
      for (int o = 0; o < OUT_DIM; o++) begin
        e0[o*N +: N] = ((o % 2 == 0) ? tbl[t].e0_even : tbl[t].e0_odd) + 16'(o) * tbl[t].emul;
        e1[o*N +: N] = ((o % 2 == 0) ? tbl[t].e1_even : tbl[t].e1_odd) + 16'(o) * tbl[t].emul;
      end
      do_job($sformatf("vec%0d", t), 1'b0, r0, r1);
      check($sformatf("vec%0d q linear", t), r0, e0);
      check($sformatf("vec%0d q relu", t), r1, e1);
      if (t == 0) begin
        // Hold with run high: q stable, no ROM reads, valid stays
        qhold = q0;
        hold_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (q0 !== qhold || w_en0 !== 1'b0 || valid0 !== 1'b1) hold_ok = 1'b0;
        end
        check("hold stable", 128'(hold_ok), 128'd1);
      end
      end_job($sformatf("vec%0d", t));
    end

    // Abort at edge 30, restart at edge 40
    for (int k = 0; k < T; k++) rom[k] = small_rand();
    for (int i = 0; i < IN_DIM; i++) xv[i] = small_rand();
    @(posedge clk); #1;
    d = pack_x();
    run = 1'b1;
    @(posedge clk);            // edge 0
    repeat (30) @(posedge clk); // edge 30
    #1;
    check("abort pre w_en", 128'(w_en0), 128'd1);
    check("abort pre addr", 128'(w_addr0), 128'd29);
    run = 1'b0;
    @(posedge clk); #1;        // edge 31
    check("abort ctl", {w_en1, w_en0, valid1, valid0}, 128'd0);
    check("abort addr hold", 128'(w_addr0), 128'd29);
    repeat (8) @(posedge clk); // edge 39
    #1;
    run = 1'b1;
    @(posedge clk);            // edge 40: new capture
    wait_valid(1'b1, n);
    check("restart latency", 128'(n), 128'(LAT));
    check("restart q linear", q0, model(1'b0));
    check("restart q relu", q1, model(1'b1));
    end_job("restart");

    // Randomised jobs with d scrambled after capture
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < T; k++) rom[k] = (r % 3 == 0) ? 16'($urandom) : small_rand();
      for (int i = 0; i < IN_DIM; i++) xv[i] = (r % 2 == 0) ? 16'($urandom) : small_rand();
      m0 = model(1'b0);
      m1 = model(1'b1);
      do_job($sformatf("rnd%0d", r), 1'b1, r0, r1);
      check($sformatf("rnd%0d q linear", r), r0, m0);
      check($sformatf("rnd%0d q relu", r), r1, m1);
      end_job($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
